// File: rtl/sq_bcd_display_pkg.sv
// Shared types and constants for the squarer BCD display block:
// conversion FSM states, field widths and 7-segment codes.
package sq_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } conv_state_t;

    localparam int SQ_W       = 6;
    localparam int BCD_W      = 4;
    localparam int CONV_STEPS = 6;

    // Shift register layout: {tens, ones, bin}
    localparam int SHIFT_W = SQ_W + 2 * BCD_W;
    localparam int TENS_LO = SQ_W + BCD_W;
    localparam int ONES_LO = SQ_W;

    // Logical (active-high) segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Double-dabble correction: a nibble of 5 or more gets 3 added so the
    // following left shift carries correctly into the next BCD digit.
    function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/sq_bcd_display_if.sv
// Conversion request/result bundle between the squarer side and the
// display block. The requester drives load/sq_in; the display block
// returns status and the last completed BCD digits.
interface sq_bcd_display_if;
    import sq_disp_pkg::*;

    logic             load;
    logic [SQ_W-1:0]  sq_in;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;

    modport master (
        output load,
        output sq_in,
        input  busy,
        input  done,
        input  tens,
        input  ones
    );

    modport slave (
        input  load,
        input  sq_in,
        output busy,
        output done,
        output tens,
        output ones
    );

endinterface

// File: rtl/sq_bcd_display_seg7_decode.sv
// Combinational BCD nibble to logical 7-segment code. Non-BCD values
// (10..15) produce a blank digit.
module seg7_decode
    import sq_disp_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    output logic [6:0]       seg
);

    // Table lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sq_bcd_display.sv
// Two-digit display driver for the 3-bit squarer result. A load strobe
// starts a six-step double-dabble conversion; the finished digits are
// time-multiplexed onto a shared 7-segment bus with leading-zero blanking.
module sq_bcd_display
    import sq_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)(
    input  logic              clk,
    input  logic              rst_n,
    sq_bcd_display_if.slave   bus,
    output logic [6:0]        seg,
    output logic [1:0]        an
);

    localparam int               RCNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REFRESH_DIV - 1);

    conv_state_t        state, state_next;
    logic [SHIFT_W-1:0] shift_q, shift_next, shift_step;
    logic [2:0]         cnt_q, cnt_next;
    logic               update_digits;

    logic [BCD_W-1:0]   tens_q, ones_q;
    logic               shown_q;

    logic [RCNT_W-1:0]  refresh_cnt;
    logic               digit_sel;

    logic [6:0]         tens_seg, ones_seg;
    logic [6:0]         seg_logic;
    logic [1:0]         an_logic;

    // One double-dabble iteration: correct both BCD nibbles, then shift left
    always_comb begin
        logic [SHIFT_W-1:0] adj;
        adj = shift_q;
        adj[TENS_LO +: BCD_W] = add3_if_ge5(shift_q[TENS_LO +: BCD_W]);
        adj[ONES_LO +: BCD_W] = add3_if_ge5(shift_q[ONES_LO +: BCD_W]);
        shift_step = {adj[SHIFT_W-2:0], 1'b0};
    end

    // Conversion FSM next-state logic; the last CONV step also publishes the digits
    always_comb begin
        state_next    = state;
        shift_next    = shift_q;
        cnt_next      = cnt_q;
        update_digits = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    shift_next = {{(2 * BCD_W){1'b0}}, bus.sq_in};
                    cnt_next   = 3'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                shift_next = shift_step;
                cnt_next   = cnt_q + 3'd1;
                if (cnt_q == 3'(CONV_STEPS - 1)) begin
                    state_next    = DONE;
                    update_digits = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Conversion FSM state, shift register and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state   <= state_next;
            shift_q <= shift_next;
            cnt_q   <= cnt_next;
        end
    end

    // Displayed digits only change when a conversion completes, never mid-way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= '0;
            ones_q  <= '0;
            shown_q <= 1'b0;
        end else if (update_digits) begin
            tens_q  <= shift_step[TENS_LO +: BCD_W];
            ones_q  <= shift_step[ONES_LO +: BCD_W];
            shown_q <= 1'b1;
        end
    end

    // Free-running refresh counter; each wrap hands the bus to the other digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == RCNT_MAX) begin
            refresh_cnt <= '0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    seg7_decode u_tens_dec (
        .digit (tens_q),
        .seg   (tens_seg)
    );

    seg7_decode u_ones_dec (
        .digit (ones_q),
        .seg   (ones_seg)
    );

    // Select the active digit, blanking a leading zero and anything before the first result
    always_comb begin
        seg_logic = SEG_BLANK;
        an_logic  = 2'b00;
        if (shown_q) begin
            if (digit_sel) begin
                if (tens_q != '0) begin
                    seg_logic = tens_seg;
                    an_logic  = 2'b10;
                end
            end else begin
                seg_logic = ones_seg;
                an_logic  = 2'b01;
            end
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~seg_logic : seg_logic;
    assign an  = SEG_ACTIVE_LOW ? ~an_logic  : an_logic;

    assign bus.busy = (state == CONV);
    assign bus.done = (state == DONE);
    assign bus.tens = tens_q;
    assign bus.ones = ones_q;

endmodule

// File: tb/tb_sq_bcd_display.sv
// Scoreboard bench for sq_bcd_display: directed loads push hand-computed
// digits; a negedge monitor pops them on done and checks status and pins.
module tb_sq_bcd_display;
    import sq_disp_pkg::*;

    localparam int DIV = 4;

    typedef struct {
        int         k;
        logic [3:0] tens;
        logic [3:0] ones;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   conv_k = -100;

    logic       m_sel  = 1'b0;
    int         m_rcnt = 0;
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;
    bit         m_shown = 1'b0;

    sq_bcd_display_if bus ();

    sq_bcd_display #(
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Expected digit-select sequence: toggles every DIV cycles after reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sel  <= 1'b0;
            m_rcnt <= 0;
        end else if (m_rcnt == DIV - 1) begin
            m_rcnt <= 0;
            m_sel  <= ~m_sel;
        end else begin
            m_rcnt <= m_rcnt + 1;
        end
    end

    // Monitor: pop expected digits on done, then check status and pin levels
    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] exp_seg;
        logic [1:0] exp_an;
        if (!rst_n) begin
            m_tens  = 4'd0;
            m_ones  = 4'd0;
            m_shown = 1'b0;
            checkOutput("rst_busy", int'(bus.busy), 0);
            checkOutput("rst_done", int'(bus.done), 0);
        end else begin
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("done_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("tens", int'(bus.tens), int'(e.tens));
                    checkOutput("ones", int'(bus.ones), int'(e.ones));
                    checkOutput("done_latency", cyc, e.k + 6);
                    m_tens  = e.tens;
                    m_ones  = e.ones;
                    m_shown = 1'b1;
                end
            end
            checkOutput("busy", int'(bus.busy), (cyc >= conv_k && cyc <= conv_k + 5) ? 1 : 0);
        end
        exp_seg = 7'b0000000;
        exp_an  = 2'b00;
        if (rst_n && m_shown) begin
            if (m_sel) begin
                if (m_tens != 4'd0) begin
                    exp_seg = segCode(m_tens);
                    exp_an  = 2'b10;
                end
            end else begin
                exp_seg = segCode(m_ones);
                exp_an  = 2'b01;
            end
        end
        exp_seg = ~exp_seg;
        exp_an  = ~exp_an;
        checkOutput("seg_pin", int'(seg), int'(exp_seg));
        checkOutput("an_pin", int'(an), int'(exp_an));
    end

    // mode 0: load expected to be ignored; 1: normal conversion; 2: conversion to be aborted
    task automatic applyStimulus(input logic [5:0] v, input int mode,
                                 input logic [3:0] t, input logic [3:0] o);
        exp_t e;
        bus.sq_in = v;
        bus.load  = 1'b1;
        if (mode == 1) begin
            e.k    = cyc + 1;
            e.tens = t;
            e.ones = o;
            sb_q.push_back(e);
        end
        if (mode != 0) conv_k = cyc + 1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.sq_in = ~v;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", sb_q.size(), 0);
    endtask

    task automatic runConv(input logic [5:0] v, input logic [3:0] t, input logic [3:0] o);
        applyStimulus(v, 1, t, o);
        waitDrain();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        bus.load  = 1'b0;
        bus.sq_in = 6'd0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tens", int'(bus.tens), 0);
        checkOutput("rst_ones", int'(bus.ones), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        runConv(6'd36, 4'd3, 4'd6);
        runConv(6'd49, 4'd4, 4'd9);
        runConv(6'd63, 4'd6, 4'd3);
        runConv(6'd9,  4'd0, 4'd9);
        runConv(6'd0,  4'd0, 4'd0);

        // Loads during CONV and during DONE are dropped; the first IDLE load converts
        applyStimulus(6'd25, 1, 4'd2, 4'd5);
        repeat (2) @(negedge clk);
        applyStimulus(6'd4, 0, 4'd0, 4'd0);
        repeat (3) @(negedge clk);
        applyStimulus(6'd4, 0, 4'd0, 4'd0);
        applyStimulus(6'd4, 1, 4'd0, 4'd4);
        waitDrain();
        repeat (10) @(negedge clk);

        // Reset in the middle of a conversion abandons it without a done pulse
        applyStimulus(6'd36, 2, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b0;
        conv_k = -100;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("abort_tens", int'(bus.tens), 0);
        checkOutput("abort_ones", int'(bus.ones), 0);

        runConv(6'd49, 4'd4, 4'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
